mem_access_stage: RTL and testbench

- MEM pipeline stage; consumes the registered EX/MEM latch outputs.
- Resolves branches (PCSrc, target) and performs data-memory loads and stores over a req/ack handshake.
- Stalls the front of the pipeline while an access is outstanding, then loads its own MEM/WB pipeline register for the WB stage.

---
 rtl/mem_access_stage_pkg.sv | 9 +
 rtl/mem_access_stage_if.sv | 7 +
 rtl/mem_access_stage_mem_wb_latch.sv | 49 ++++
 rtl/mem_access_stage.sv | 114 +++++++++++
 tb/tb_mem_access_stage.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/mem_access_stage_pkg.sv
// mem_access_stage_pkg: shared state encodings, bubble control value and default widths/timeout for the MEM stage.
package mem_access_stage_pkg;
   localparam int B_DEF = 32;
   localparam int W_DEF = 5;
   localparam int TIMEOUT_DEF = 255;
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_ACCESS = 1'b1;
   localparam logic [1:0] BUBBLE_CTRL = 2'b00;
endpackage

// File: rtl/mem_access_stage_if.sv
// mem_access_stage_if: data-memory req/ack bus between the MEM stage (master) and memory (slave).
interface mem_access_stage_if #(parameter int B = 32);
   logic req, we, ack;
   logic [B-1:0] addr, wdata, rdata;
   modport master(output req, we, addr, wdata, input ack, rdata);
   modport slave(input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/mem_access_stage_mem_wb_latch.sv
// mem_wb_latch: MEM/WB pipeline register; load takes all fields, bubble clears only the WB controls.
module mem_wb_latch
   import mem_access_stage_pkg::*;
#(
   parameter int B = B_DEF,
   parameter int W = W_DEF
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         load,
   input  logic         bubble,
   input  logic [B-1:0] read_data_in,
   input  logic [B-1:0] alu_result_in,
   input  logic [W-1:0] write_reg_in,
   input  logic         reg_write_in,
   input  logic         mem_to_reg_in,
   output logic [B-1:0] read_data_out,
   output logic [B-1:0] alu_result_out,
   output logic [W-1:0] write_reg_out,
   output logic         reg_write_out,
   output logic         mem_to_reg_out
);
   logic [B-1:0] read_data_q, read_data_d, alu_result_q, alu_result_d;
   logic [W-1:0] write_reg_q, write_reg_d;
   logic [1:0] ctrl_q, ctrl_d;
   always_comb begin
      read_data_d = load ? read_data_in : read_data_q;
      alu_result_d = load ? alu_result_in : alu_result_q;
      write_reg_d = load ? write_reg_in : write_reg_q;
      ctrl_d = load ? {reg_write_in, mem_to_reg_in} : bubble ? BUBBLE_CTRL : ctrl_q;
   end
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         read_data_q <= '0;
         alu_result_q <= '0;
         write_reg_q <= '0;
         ctrl_q <= '0;
      end else begin
         read_data_q <= read_data_d;
         alu_result_q <= alu_result_d;
         write_reg_q <= write_reg_d;
         ctrl_q <= ctrl_d;
      end
   end
   assign read_data_out = read_data_q;
   assign alu_result_out = alu_result_q;
   assign write_reg_out = write_reg_q;
   assign {reg_write_out, mem_to_reg_out} = ctrl_q;
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM stage with branch resolve, req/ack data-memory access and MEM/WB register.
// Define MEM_STAGE_TIMEOUT_EN to abort accesses that see no ack within TIMEOUT cycles.
module mem_access_stage
   import mem_access_stage_pkg::*;
#(
   parameter int B = B_DEF,
   parameter int W = W_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic [B-1:0] add_result_in,
   input  logic [B-1:0] alu_result_in,
   input  logic [B-1:0] r_data2_in,
   input  logic [W-1:0] mux_RegDst_in,
   input  logic         zero_in,
   input  logic         wb_RegWrite_in,
   input  logic         wb_MemtoReg_in,
   input  logic         m_Branch_in,
   input  logic         m_MemRead_in,
   input  logic         m_MemWrite_in,
   input  logic         flush_in,
   output logic         pc_src_out,
   output logic [B-1:0] branch_target_out,
   output logic         stall_out,
   mem_access_stage_if.master dmem,
   output logic [B-1:0] read_data_out,
   output logic [B-1:0] alu_result_out,
   output logic [W-1:0] write_reg_out,
   output logic         wb_RegWrite_out,
   output logic         wb_MemtoReg_out,
   output logic         timeout_err_out
);
   logic [0:0] state_q, state_d;
   logic req_q, req_d, we_q, we_d;
   logic [B-1:0] addr_q, addr_d, wdata_q, wdata_d, rd_data;
   logic in_access, mem_op, issue, done, tmo, load;
   assign in_access = state_q == ST_ACCESS;
   always_comb begin
      mem_op = (m_MemRead_in | m_MemWrite_in) & ~flush_in;
      issue = ~in_access & mem_op;
      done = in_access & (dmem.ack | tmo);
      stall_out = in_access ? ~(dmem.ack | tmo) : mem_op;
      load = in_access ? dmem.ack : ~mem_op & ~flush_in;
      rd_data = (in_access & m_MemRead_in) ? dmem.rdata : '0;
      state_d = done ? ST_IDLE : issue ? ST_ACCESS : state_q;
      req_d = issue | (req_q & ~done);
      we_d = issue ? m_MemWrite_in : we_q;
      addr_d = issue ? alu_result_in : addr_q;
      wdata_d = issue ? r_data2_in : wdata_q;
   end
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         req_q <= 1'b0;
         we_q <= 1'b0;
         addr_q <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         req_q <= req_d;
         we_q <= we_d;
         addr_q <= addr_d;
         wdata_q <= wdata_d;
      end
   end
`ifdef MEM_STAGE_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] cnt_q, cnt_d;
   logic err_q, err_d;
   always_comb begin
      tmo = in_access & ~dmem.ack & (cnt_q == CW'(TIMEOUT - 1));
      cnt_d = in_access ? cnt_q + 1'b1 : '0;
      err_d = err_q | tmo;
   end
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end
   assign timeout_err_out = err_q;
`else
   logic unused_timeout;
   assign unused_timeout = |TIMEOUT;
   assign tmo = 1'b0;
   assign timeout_err_out = 1'b0;
`endif
   assign pc_src_out = m_Branch_in & zero_in & ~flush_in;
   assign branch_target_out = add_result_in;
   assign dmem.req = req_q;
   assign dmem.we = we_q;
   assign dmem.addr = addr_q;
   assign dmem.wdata = wdata_q;
   mem_wb_latch #(.B(B), .W(W)) u_mem_wb (
      .clk(clk),
      .reset_n(reset_n),
      .load(load),
      .bubble(~load),
      .read_data_in(rd_data),
      .alu_result_in(alu_result_in),
      .write_reg_in(mux_RegDst_in),
      .reg_write_in(wb_RegWrite_in),
      .mem_to_reg_in(wb_MemtoReg_in),
      .read_data_out(read_data_out),
      .alu_result_out(alu_result_out),
      .write_reg_out(write_reg_out),
      .reg_write_out(wb_RegWrite_out),
      .mem_to_reg_out(wb_MemtoReg_out)
   );
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed stimulus against a cycle-level behavioural model of the MEM stage.
module tb_mem_access_stage;
   localparam int TMO = 4;
`ifdef MEM_STAGE_TIMEOUT_EN
   localparam bit TEN = 1'b1;
`else
   localparam bit TEN = 1'b0;
`endif
   logic clk = 1'b0, reset_n = 1'b0;
   logic [31:0] add_result_in, alu_result_in, r_data2_in;
   logic [4:0] mux_RegDst_in;
   logic zero_in, wb_RegWrite_in, wb_MemtoReg_in, m_Branch_in, m_MemRead_in, m_MemWrite_in, flush_in;
   logic pc_src_out, stall_out, wb_RegWrite_out, wb_MemtoReg_out, timeout_err_out;
   logic [31:0] branch_target_out, read_data_out, alu_result_out;
   logic [4:0] write_reg_out;
   int n_chk = 0, n_fail = 0;
   mem_access_stage_if #(.B(32)) bus ();
   mem_access_stage #(.B(32), .W(5), .TIMEOUT(TMO)) dut (
      .clk(clk), .reset_n(reset_n), .add_result_in(add_result_in), .alu_result_in(alu_result_in),
      .r_data2_in(r_data2_in), .mux_RegDst_in(mux_RegDst_in), .zero_in(zero_in),
      .wb_RegWrite_in(wb_RegWrite_in), .wb_MemtoReg_in(wb_MemtoReg_in), .m_Branch_in(m_Branch_in),
      .m_MemRead_in(m_MemRead_in), .m_MemWrite_in(m_MemWrite_in), .flush_in(flush_in),
      .pc_src_out(pc_src_out), .branch_target_out(branch_target_out), .stall_out(stall_out),
      .dmem(bus), .read_data_out(read_data_out), .alu_result_out(alu_result_out),
      .write_reg_out(write_reg_out), .wb_RegWrite_out(wb_RegWrite_out),
      .wb_MemtoReg_out(wb_MemtoReg_out), .timeout_err_out(timeout_err_out)
   );
   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      n_chk++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s actual=%h required=%h at %0t", n, a, e, $time);
      end
   endtask

   // Model: an access is a pending transaction with an age; the MEM/WB register is a plain record.
   bit started = 0, busy = 0, m_req = 0, m_we = 0, m_rw = 0, m_mtr = 0, m_err = 0;
   int age = 0;
   logic [31:0] m_addr = 0, m_wdata = 0, m_rd = 0, m_alu = 0;
   logic [4:0] m_wr = 0;
   function automatic bit op_now();
      return (m_MemRead_in | m_MemWrite_in) & ~flush_in;
   endfunction
   function automatic bit exp_stall();
      if (busy) return !(bus.ack || (TEN && age + 1 == TMO));
      return op_now();
   endfunction
   always @(posedge clk) begin
      started = 1;
      if (!reset_n) begin
         busy = 0; age = 0; m_req = 0; m_we = 0; m_addr = 0; m_wdata = 0;
         m_rd = 0; m_alu = 0; m_wr = 0; m_rw = 0; m_mtr = 0; m_err = 0;
      end else if (busy && bus.ack) begin
         busy = 0; m_req = 0;
         m_rd = m_MemRead_in ? bus.rdata : 32'h0;
         m_alu = alu_result_in; m_wr = mux_RegDst_in; m_rw = wb_RegWrite_in; m_mtr = wb_MemtoReg_in;
      end else if (busy) begin
         age++;
         if (TEN && age == TMO) begin busy = 0; m_req = 0; m_err = 1; end
         m_rw = 0; m_mtr = 0;
      end else if (op_now()) begin
         busy = 1; age = 0; m_req = 1; m_we = m_MemWrite_in; m_addr = alu_result_in; m_wdata = r_data2_in;
         m_rw = 0; m_mtr = 0;
      end else if (flush_in) begin
         m_rw = 0; m_mtr = 0;
      end else begin
         m_rd = 0; m_alu = alu_result_in; m_wr = mux_RegDst_in; m_rw = wb_RegWrite_in; m_mtr = wb_MemtoReg_in;
      end
   end
   always @(negedge clk) if (started) begin
      chk("pc_src", 32'(pc_src_out), 32'(m_Branch_in & zero_in & ~flush_in));
      chk("target", branch_target_out, add_result_in);
      chk("stall", 32'(stall_out), 32'(exp_stall()));
      chk("req", 32'(bus.req), 32'(m_req));
      chk("we", 32'(bus.we), 32'(m_we));
      chk("addr", bus.addr, m_addr);
      chk("wdata", bus.wdata, m_wdata);
      chk("read_data", read_data_out, m_rd);
      chk("alu_out", alu_result_out, m_alu);
      chk("write_reg", 32'(write_reg_out), 32'(m_wr));
      chk("ctrl", {30'h0, wb_RegWrite_out, wb_MemtoReg_out}, {30'h0, m_rw, m_mtr});
      chk("tmo_err", 32'(timeout_err_out), 32'(m_err));
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask
   task automatic idle();
      m_Branch_in = 0; m_MemRead_in = 0; m_MemWrite_in = 0; flush_in = 0; zero_in = 0;
      wb_RegWrite_in = 0; wb_MemtoReg_in = 0; bus.ack = 0;
   endtask

   initial begin
      int stalls;
      add_result_in = 32'h55; alu_result_in = 32'h77; r_data2_in = 32'h99; mux_RegDst_in = 5'd3;
      zero_in = 1; wb_RegWrite_in = 1; wb_MemtoReg_in = 1; m_Branch_in = 1; m_MemRead_in = 1;
      m_MemWrite_in = 1; flush_in = 0; bus.ack = 1; bus.rdata = 32'h1234_5678;
      step(); step();
      @(negedge clk);
      chk("rst_req", 32'(bus.req), 32'h0);
      chk("rst_alu", alu_result_out, 32'h0);
      chk("rst_rw", 32'(wb_RegWrite_out), 32'h0);
      idle(); reset_n = 1;
      @(negedge clk);
      chk("rel_stall", 32'(stall_out), 32'h0);
      // ALU op
      step(); alu_result_in = 32'h10; mux_RegDst_in = 5'd5; wb_RegWrite_in = 1;
      step(); idle();
      @(negedge clk);
      chk("alu_lit", alu_result_out, 32'h10);
      chk("wreg_lit", 32'(write_reg_out), 32'd5);
      chk("rw_lit", 32'(wb_RegWrite_out), 32'h1);
      chk("alu_noreq", 32'(bus.req), 32'h0);
      // Load, ack in fourth ACCESS cycle
      step(); m_MemRead_in = 1; wb_MemtoReg_in = 1; wb_RegWrite_in = 1; alu_result_in = 32'h40; mux_RegDst_in = 5'd7;
      stalls = 0;
      for (int i = 0; i < 5; i++) begin
         bus.ack = (i == 4); bus.rdata = (i == 4) ? 32'hDEAD_BEEF : 32'h0BAD_0BAD;
         @(negedge clk);
         stalls += int'(stall_out);
         if (i > 0) chk("ld_addr", bus.addr, 32'h40);
         if (i > 0) chk("ld_bubble", 32'(wb_RegWrite_out), 32'h0);
         step();
      end
      idle();
      @(negedge clk);
      chk("ld_stalls", 32'(stalls), 32'd4);
      chk("ld_data", read_data_out, 32'hDEAD_BEEF);
      chk("ld_mtr", 32'(wb_MemtoReg_out), 32'h1);
      // Store, ack in first ACCESS cycle
      step(); m_MemWrite_in = 1; alu_result_in = 32'h80; r_data2_in = 32'h0000_1234;
      step(); bus.ack = 1;
      @(negedge clk);
      chk("st_we", 32'(bus.we), 32'h1);
      chk("st_wdata", bus.wdata, 32'h1234);
      step(); idle();
      @(negedge clk);
      chk("st_rd", read_data_out, 32'h0);
      // Branch
      step(); m_Branch_in = 1; zero_in = 1; add_result_in = 32'h100;
      #1 chk("br_taken", 32'(pc_src_out), 32'h1);
      chk("br_target", branch_target_out, 32'h100);
      zero_in = 0;
      #1 chk("br_not", 32'(pc_src_out), 32'h0);
      // Flushed store never requests
      step(); idle(); m_MemWrite_in = 1; flush_in = 1; wb_RegWrite_in = 1; alu_result_in = 32'hC0;
      for (int i = 0; i < 2; i++) begin
         step();
         @(negedge clk);
         chk("fl_noreq", 32'(bus.req), 32'h0);
         chk("fl_bubble", 32'(wb_RegWrite_out), 32'h0);
      end
      // Flush during ACCESS is ignored
      flush_in = 0; wb_RegWrite_in = 0; alu_result_in = 32'hE0;
      step(); flush_in = 1;
      step(); bus.ack = 1;
      @(negedge clk);
      chk("fla_req", 32'(bus.req), 32'h1);
      step(); idle();
      @(negedge clk);
      chk("fla_done", alu_result_out, 32'hE0);
      // No ack: timeout abort or indefinite stall
      step(); m_MemRead_in = 1; wb_RegWrite_in = 1; alu_result_in = 32'h44;
      for (int i = 0; i < 7; i++) step();
      m_MemRead_in = 0;
      @(negedge clk);
      chk("to_err", 32'(timeout_err_out), TEN ? 32'h1 : 32'h0);
      chk("to_req", 32'(bus.req), TEN ? 32'h0 : 32'h1);
      step(); step();
      @(negedge clk);
      chk("to_sticky", 32'(timeout_err_out), TEN ? 32'h1 : 32'h0);
      // Reset beats a simultaneous ack
      bus.ack = 1; reset_n = 0;
      step(); reset_n = 1;
      step(); bus.ack = 0;
      @(negedge clk);
      chk("rst_ack_req", 32'(bus.req), 32'h0);
      chk("rst_err", 32'(timeout_err_out), 32'h0);
      step(); step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
